// File: rtl/psum_collector_pkg.sv
// Shared constants, FSM state type and requantization for the PE-column psum collector.
package pe_pkg;
    localparam int PSUM_W = 14;
    localparam int ACC_W  = 18;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 5;

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    // Logical right shift, then clamp anything above the output range to all ones.
    function automatic logic [OUT_W-1:0] requant(input logic [ACC_W-1:0] sum,
                                                 input logic [3:0]       sh);
        logic [ACC_W-1:0] q;
        q = sum >> sh;
        return (|q[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : q[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/psum_collector_if.sv
// Psum input stream plus valid/ready result stream of the psum collector.
interface psum_collector_if;
    import pe_pkg::*;

    logic              psum_valid;
    logic [PSUM_W-1:0] psum_in;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport master (output psum_valid, psum_in, out_ready, input out_valid, out_data);
    modport slave  (input psum_valid, psum_in, out_ready, output out_valid, out_data);
endinterface

// File: rtl/psum_collector_fifo.sv
// Small synchronous result FIFO; a push while full only lands if a pop frees the slot.
module psum_fifo
    import pe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = OUT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         full, wr_en, rd_en;

    assign count = wptr - rptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/psum_collector.sv
// Accumulates N partial sums per output pixel, requantizes to 8 bits and queues results.
module psum_collector
    import pe_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [3:0]       acc_len,
    input  logic [3:0]       shift,
    psum_collector_if.slave  bus,
    output logic             busy,
    output logic             ovf_err
);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx, sum;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc, n_terms;
    logic             q_vld, q_vld_nx;
    logic [OUT_W-1:0] q_data, q_data_nx;
    logic             term, push, pop, full, fifo_empty;
    logic [FCW-1:0]   fifo_cnt;

    assign term    = en & bus.psum_valid & ~clear;
    assign n_terms = (acc_len == 4'd0) ? CNT_W'(16) : CNT_W'(acc_len);
    // In IDLE the incoming term starts a fresh pixel, so the old acc/count are ignored.
    assign sum     = ((state == ACCUM) ? acc : '0) + ACC_W'(bus.psum_in);
    assign cnt_inc = ((state == ACCUM) ? cnt : '0) + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            q_vld  <= 1'b0;
            q_data <= '0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            cnt    <= cnt_nx;
            q_vld  <= q_vld_nx;
            q_data <= q_data_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = cnt;
        q_vld_nx  = 1'b0;
        q_data_nx = q_data;
        if (clear) begin
            state_nx = IDLE;
            acc_nx   = '0;
            cnt_nx   = '0;
        end else if (term) begin
            // >= so a mid-pixel shrink of acc_len still terminates on the next term.
            if (cnt_inc >= n_terms) begin
                state_nx  = IDLE;
                acc_nx    = '0;
                cnt_nx    = '0;
                q_vld_nx  = 1'b1;
                q_data_nx = requant(sum, shift);
            end else begin
                state_nx = ACCUM;
                acc_nx   = sum;
                cnt_nx   = cnt_inc;
            end
        end
    end

    assign push = q_vld & ~clear;
    assign pop  = bus.out_valid & bus.out_ready;
    assign full = (fifo_cnt == FCW'(FIFO_DEPTH));

    psum_fifo #(.DEPTH(FIFO_DEPTH), .W(OUT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (q_data),
        .rdata (bus.out_data),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign bus.out_valid = ~fifo_empty;
    assign busy          = (state == ACCUM) | q_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    ovf_err <= 1'b0;
        else if (clear)                ovf_err <= 1'b0;
        else if (push & full & ~pop)   ovf_err <= 1'b1;
    end
endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_psum_collector;
    import pe_pkg::*;

    typedef struct {
        int len;
        int sh;
        int n;
        int base;
        int stp;
        int exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] acc_len = 4'd0;
    logic [3:0] shift = 4'd0;
    logic       busy, ovf_err;
    int         nchk = 0;
    int         nerr = 0;

    psum_collector_if bus();

    psum_collector #(.FIFO_DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clear   (clear),
        .acc_len (acc_len),
        .shift   (shift),
        .bus     (bus),
        .busy    (busy),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int val);
        bus.psum_valid = v;
        bus.psum_in    = PSUM_W'(val);
        step();
    endtask

    // Called in the cycle right after the final term: result shows up one cycle later.
    task automatic expect_result(input string name, input int exp);
        bus.psum_valid = 1'b0;
        chk({name, "_early_valid"}, int'(bus.out_valid), 0);
        chk({name, "_busy_quant"}, int'(busy), 1);
        step();
        chk({name, "_valid"}, int'(bus.out_valid), 1);
        chk({name, "_data"}, int'(bus.out_data), exp);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({name, "_drained"}, int'(bus.out_valid), 0);
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        vec_t tbl[8];
        int   m_q[$];
        int   m_sum, m_cnt, m_pd, n, q;
        bit   m_pv, m_ovf, pop, term;

        tbl[0] = '{3, 0, 3, 10, 10, 60};
        tbl[1] = '{3, 2, 3, 1000, 0, 255};
        tbl[2] = '{3, 4, 3, 1000, 0, 187};
        tbl[3] = '{0, 15, 16, 16383, 0, 7};
        tbl[4] = '{0, 10, 16, 16383, 0, 255};
        tbl[5] = '{1, 0, 1, 200, 0, 200};
        tbl[6] = '{2, 1, 2, 100, -49, 75};
        tbl[7] = '{5, 3, 5, 1, 1, 1};

        bus.psum_valid = 1'b0;
        bus.psum_in    = '0;
        bus.out_ready  = 1'b0;
        step();
        step();
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf_err), 0);
        rst_n = 1'b1;
        step();

        en = 1'b1;
        foreach (tbl[i]) begin
            acc_len = 4'(tbl[i].len);
            shift   = 4'(tbl[i].sh);
            for (int k = 0; k < tbl[i].n; k++) drive(1'b1, tbl[i].base + k * tbl[i].stp);
            expect_result($sformatf("vec%0d", i), tbl[i].exp);
        end

        // FIFO overflow: 1..4 buffered, 5 dropped, sticky error until clear
        acc_len = 4'd1;
        shift   = 4'd0;
        for (int k = 1; k <= 5; k++) drive(1'b1, k);
        bus.psum_valid = 1'b0;
        chk("ovf_not_yet", int'(ovf_err), 0);
        step();
        chk("ovf_set", int'(ovf_err), 1);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_drain_valid%0d", k), int'(bus.out_valid), 1);
            chk($sformatf("ovf_drain_data%0d", k), int'(bus.out_data), k);
            step();
        end
        bus.out_ready = 1'b0;
        chk("ovf_empty", int'(bus.out_valid), 0);
        chk("ovf_sticky", int'(ovf_err), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("ovf_cleared", int'(ovf_err), 0);

        // en low mid-pixel holds the partial sum
        acc_len = 4'd3;
        drive(1'b1, 7);
        drive(1'b1, 8);
        en = 1'b0;
        repeat (4) drive(1'b1, 99);
        chk("en_low_busy", int'(busy), 1);
        en = 1'b1;
        drive(1'b1, 9);
        expect_result("en_gap", 24);

        // clear with a term present discards both the partial and the term
        drive(1'b1, 4);
        drive(1'b1, 5);
        clear = 1'b1;
        drive(1'b1, 100);
        clear = 1'b0;
        chk("clr_busy", int'(busy), 0);
        drive(1'b1, 1);
        drive(1'b1, 2);
        drive(1'b1, 3);
        expect_result("clr_after", 6);

        // clear while the quant register is loaded suppresses the push
        acc_len = 4'd1;
        drive(1'b1, 50);
        bus.psum_valid = 1'b0;
        chk("clrq_busy", int'(busy), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clrq_idle", int'(busy), 0);
        step();
        chk("clrq_no_push", int'(bus.out_valid), 0);

        // async reset mid-pixel, with a result already queued
        drive(1'b1, 42);
        bus.psum_valid = 1'b0;
        step();
        chk("prerst_valid", int'(bus.out_valid), 1);
        chk("prerst_data", int'(bus.out_data), 42);
        acc_len = 4'd3;
        drive(1'b1, 5);
        bus.psum_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(bus.out_valid), 0);
        chk("arst_data", int'(bus.out_data), 0);
        chk("arst_busy", int'(busy), 0);
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 1);
        drive(1'b1, 2);
        drive(1'b1, 3);
        expect_result("arst_after", 6);

        // random traffic against a transaction-level model
        m_sum = 0; m_cnt = 0; m_pd = 0; m_pv = 0; m_ovf = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en             = ($urandom_range(0, 9) != 0);
            bus.psum_valid = ($urandom_range(0, 3) != 0);
            bus.psum_in    = PSUM_W'($urandom_range(0, 16383));
            bus.out_ready  = ($urandom_range(0, 2) == 0);
            clear          = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) acc_len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) shift = 4'($urandom_range(0, 15));

            chk("rnd_valid", int'(bus.out_valid), int'(m_q.size() > 0));
            if (m_q.size() > 0) chk("rnd_data", int'(bus.out_data), m_q[0]);
            chk("rnd_busy", int'(busy), int'(m_cnt > 0 || m_pv));
            chk("rnd_ovf", int'(ovf_err), int'(m_ovf));

            n    = (acc_len == 4'd0) ? 16 : int'(acc_len);
            pop  = (m_q.size() > 0) && bus.out_ready;
            term = en && bus.psum_valid && !clear;
            if (pop) void'(m_q.pop_front());
            if (clear) begin
                m_sum = 0; m_cnt = 0; m_pv = 0; m_ovf = 0;
            end else begin
                if (m_pv) begin
                    if (m_q.size() < 4) m_q.push_back(m_pd);
                    else m_ovf = 1;
                    m_pv = 0;
                end
                if (term) begin
                    m_sum += int'(bus.psum_in);
                    m_cnt++;
                    if (m_cnt >= n) begin
                        q     = m_sum >> int'(shift);
                        m_pd  = (q > 255) ? 255 : q;
                        m_pv  = 1;
                        m_sum = 0;
                        m_cnt = 0;
                    end
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
